fnd_scan_driver: RTL and testbench

//  Downstream display stage: takes the 8-bit money value from main_logic and drives the 8-digit FND array.

---
 rtl/fnd_scan_driver.sv | 131 +++++++++++++
 tb/tb_fnd_scan_driver.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/fnd_scan_driver.sv
// 8-digit FND scan driver: sequential double-dabble of an 8-bit value into 3 BCD digits, shown on the 3 rightmost digits.
// Optional macro FND_LEADING_ZERO_BLANK_EN blanks leading zeros on the hundreds/tens digits.
module fnd_scan_driver #(
  parameter int SCAN_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] display_money_bin,
  output logic       conv_busy,
  output logic [7:0] seg_com,
  output logic [7:0] seg_array
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  state_t        state_reg;
  logic [7:0]    sampled_reg;
  logic [7:0]    bin_reg;
  logic [11:0]   work_bcd_reg;
  logic [2:0]    shift_cnt_reg;
  logic [11:0]   disp_bcd_reg;
  logic [PW-1:0] presc_reg;
  logic [2:0]    idx_reg;
  logic [11:0]   adj_bcd;
  logic [7:0]    digit_pattern;

  // Add-3 correction on each BCD nibble before the shift
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_adj
      assign adj_bcd[gi*4 +: 4] = (work_bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                  work_bcd_reg[gi*4 +: 4] + 4'd3 :
                                  work_bcd_reg[gi*4 +: 4];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      sampled_reg   <= 8'd0;
      bin_reg       <= 8'd0;
      work_bcd_reg  <= 12'd0;
      shift_cnt_reg <= 3'd0;
      disp_bcd_reg  <= 12'd0;
      conv_busy     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (display_money_bin != sampled_reg) begin
            sampled_reg   <= display_money_bin;
            bin_reg       <= display_money_bin;
            work_bcd_reg  <= 12'd0;
            shift_cnt_reg <= 3'd0;
            conv_busy     <= 1'b1;
            state_reg     <= SHIFT;
          end
        end
        SHIFT: begin
          {work_bcd_reg, bin_reg} <= {adj_bcd, bin_reg} << 1;
          shift_cnt_reg <= shift_cnt_reg + 3'd1;
          if (shift_cnt_reg == 3'd7) begin
            state_reg <= LOAD;
          end
        end
        LOAD: begin
          // All three digits move together so the display never shows a partial result
          disp_bcd_reg <= work_bcd_reg;
          conv_busy    <= 1'b0;
          state_reg    <= IDLE;
        end
        default: begin
          conv_busy <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 8'hFC;
      4'd1:    return 8'h60;
      4'd2:    return 8'hDA;
      4'd3:    return 8'hF2;
      4'd4:    return 8'h66;
      4'd5:    return 8'hB6;
      4'd6:    return 8'hBE;
      4'd7:    return 8'hE0;
      4'd8:    return 8'hFE;
      4'd9:    return 8'hF6;
      default: return 8'h00;
    endcase
  endfunction

  always_comb begin
    digit_pattern = 8'h00;
    case (idx_reg)
      3'd0: digit_pattern = seg_decode(disp_bcd_reg[3:0]);
`ifdef FND_LEADING_ZERO_BLANK_EN
      3'd1: digit_pattern = (disp_bcd_reg[11:4] == 8'd0) ? 8'h00 : seg_decode(disp_bcd_reg[7:4]);
      3'd2: digit_pattern = (disp_bcd_reg[11:8] == 4'd0) ? 8'h00 : seg_decode(disp_bcd_reg[11:8]);
`else
      3'd1: digit_pattern = seg_decode(disp_bcd_reg[7:4]);
      3'd2: digit_pattern = seg_decode(disp_bcd_reg[11:8]);
`endif
      default: digit_pattern = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_reg <= '0;
      idx_reg   <= 3'd0;
      seg_com   <= 8'hFF;
      seg_array <= 8'h00;
    end else begin
      if (presc_reg == PRESC_MAX) begin
        presc_reg <= '0;
        idx_reg   <= idx_reg + 3'd1;
      end else begin
        presc_reg <= presc_reg + PW'(1);
      end
      seg_com   <= ~(8'b1 << idx_reg);
      seg_array <= digit_pattern;
    end
  end

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Self-checking bench for fnd_scan_driver: directed plus random values against a decimal-arithmetic display model.
module tb_fnd_scan_driver;
  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] display_money_bin = 8'd0;
  logic       conv_busy;
  logic [7:0] seg_com;
  logic [7:0] seg_array;

  int total = 0;
  int bad = 0;
  int k = 0;
  int last_v = 0;

  fnd_scan_driver #(.SCAN_DIV(SD)) dut (
    .clk(clk),
    .rst(rst),
    .display_money_bin(display_money_bin),
    .conv_busy(conv_busy),
    .seg_com(seg_com),
    .seg_array(seg_array)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release; drives the expected scan position
  always @(posedge clk or negedge rst) begin
    if (!rst) k <= 0;
    else k <= k + 1;
  end

  function automatic logic [7:0] code(input int d);
    logic [7:0] tbl [10];
    tbl = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};
    return tbl[d];
  endfunction

  function automatic logic [7:0] exp_pat(input int v, input int idx);
    bit blank;
`ifdef FND_LEADING_ZERO_BLANK_EN
    blank = 1'b1;
`else
    blank = 1'b0;
`endif
    case (idx)
      0: return code(v % 10);
      1: return (blank && v < 10) ? 8'h00 : code((v / 10) % 10);
      2: return (blank && v < 100) ? 8'h00 : code(v / 100);
      default: return 8'h00;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (conv_busy === 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic check_scan(input int v, input int ncyc);
    int idx;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      idx = ((k - 1) / SD) % 8;
      chk($sformatf("com v=%0d k=%0d", v, k), {24'd0, seg_com}, {24'd0, ~(8'b1 << idx)});
      chk($sformatf("seg v=%0d idx=%0d", v, idx), {24'd0, seg_array}, {24'd0, exp_pat(v, idx)});
    end
  endtask

  task automatic apply(input int v);
    int n;
    @(negedge clk);
    display_money_bin = 8'(v);
    @(negedge clk);
    count_busy(n);
    chk($sformatf("busy_len v=%0d", v), n, (v != last_v) ? 9 : 0);
    $display("apply value=%0d busy_cycles=%0d", v, n);
    last_v = v;
    check_scan(v, 34);
  endtask

  initial begin
    int n;
    logic [31:0] bpat;
    logic [31:0] bexp;

    // Reset state
    #12;
    chk("rst_com", {24'd0, seg_com}, 32'hFF);
    chk("rst_seg", {24'd0, seg_array}, 32'h00);
    chk("rst_busy", {31'd0, conv_busy}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    check_scan(0, 34);

    // Directed values: max, blanking, boundaries
    apply(255);
    apply(7);
    apply(0);
    apply(9);
    apply(10);
    apply(99);
    apply(100);

    // Change during conversion: 100 is captured, then 42 arrives on the 3rd shift cycle
    apply(0);
    @(negedge clk);
    display_money_bin = 8'd100;
    bpat = 32'd0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      bpat[i] = conv_busy;
      if (i == 2) display_money_bin = 8'd42;
    end
    bexp = 32'h0007FDFF;
    chk("midchange_busy_pattern", bpat, bexp);
    $display("midchange 100->42 busy_pattern=%h", bpat);
    last_v = 42;
    check_scan(42, 34);

    // Random values
    for (int r = 0; r < 8; r++) begin
      apply(int'($urandom_range(0, 255)));
    end

    // Async reset mid-conversion and mid-scan
    @(negedge clk);
    display_money_bin = 8'd200;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("async_com", {24'd0, seg_com}, 32'hFF);
    chk("async_seg", {24'd0, seg_array}, 32'h00);
    chk("async_busy", {31'd0, conv_busy}, 32'd0);
    $display("async reset asserted mid-shift");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("release_busy", {31'd0, conv_busy}, 32'd0);
    @(negedge clk);
    chk("release_com", {24'd0, seg_com}, 32'hFE);
    chk("release_seg", {24'd0, seg_array}, 32'hFC);
    count_busy(n);
    chk("reconv_busy_len", n, 9);
    $display("reconvert value=200 busy_cycles=%0d", n);
    last_v = 200;
    check_scan(200, 34);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
